// File: rtl/me_search_sequencer.sv
// Motion-estimator search sequencer: issues one ME search per macroblock, checks the start/completed handshake,
// and queues results in a FWFT FIFO. Optional frame SAD accumulator enabled by ME_SEQ_SAD_ACCUM_EN.
module me_search_sequencer #(
    parameter int NUM_BLOCKS    = 16,
    parameter int SEARCH_CYCLES = 4112,
    parameter int TIMEOUT       = 64,
    parameter int FIFO_DEPTH    = 4,
    localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             frame_go,
    output logic             frame_busy,
    output logic             frame_done,
    output logic             me_start,
    input  logic             me_completed,
    input  logic [7:0]       me_best_dist,
    input  logic [3:0]       me_motion_x,
    input  logic [3:0]       me_motion_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IDX_W+15:0] res_data,
`ifdef ME_SEQ_SAD_ACCUM_EN
    output logic [15:0]      frame_sad,
`endif
    output logic             proto_err,
    output logic             timeout_err
);
    localparam int CNT_MAX = (SEARCH_CYCLES > TIMEOUT) ? SEARCH_CYCLES : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int FCNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0]  SEARCH_LAST  = CNT_W'(SEARCH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  LAST_BLK     = IDX_W'(NUM_BLOCKS - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL    = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_SETTLE = 3'd2,
        S_WAIT   = 3'd3,
        S_PUSH   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [IDX_W-1:0]    blk_idx_r;
    logic                me_start_r;
    logic                frame_busy_r;
    logic                frame_done_r;
    logic                proto_err_r;
    logic                timeout_err_r;
    logic [7:0]          ent_dist_r;
    logic [3:0]          ent_mx_r;
    logic [3:0]          ent_my_r;
    logic                ent_flag_r;

    logic [IDX_W+15:0]   fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [FCNT_W-1:0]   fifo_cnt_r;
    logic                fifo_full_s;
    logic                push_s;
    logic                pop_s;
    logic [IDX_W+15:0]   entry_s;

    // FIFO handshake decode; a full FIFO holds the FSM in PUSH
    always_comb begin
        fifo_full_s = (fifo_cnt_r == FIFO_FULL);
        entry_s     = {blk_idx_r, ent_flag_r, 3'b000, ent_dist_r, ent_my_r, ent_mx_r};
        if (state_r == S_PUSH) begin
            push_s = !fifo_full_s;
        end else begin
            push_s = 1'b0;
        end
        if (fifo_cnt_r != {FCNT_W{1'b0}}) begin
            pop_s = res_ready;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Search sequencing FSM with registered handshake outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= S_IDLE;
            cnt_r         <= '0;
            blk_idx_r     <= '0;
            me_start_r    <= 1'b0;
            frame_busy_r  <= 1'b0;
            frame_done_r  <= 1'b0;
            timeout_err_r <= 1'b0;
            ent_dist_r    <= 8'h00;
            ent_mx_r      <= 4'h0;
            ent_my_r      <= 4'h0;
            ent_flag_r    <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (frame_go) begin
                        blk_idx_r    <= '0;
                        cnt_r        <= '0;
                        me_start_r   <= 1'b1;
                        frame_busy_r <= 1'b1;
                        state_r      <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_r == SEARCH_LAST) begin
                        cnt_r      <= '0;
                        me_start_r <= 1'b0;
                        state_r    <= S_SETTLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    state_r <= S_WAIT;
                end
                S_WAIT: begin
                    if (me_completed) begin
                        ent_dist_r <= me_best_dist;
                        ent_mx_r   <= me_motion_x;
                        ent_my_r   <= me_motion_y;
                        ent_flag_r <= 1'b0;
                        state_r    <= S_PUSH;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        ent_dist_r    <= 8'hFF;
                        ent_mx_r      <= 4'h0;
                        ent_my_r      <= 4'h0;
                        ent_flag_r    <= 1'b1;
                        timeout_err_r <= 1'b1;
                        state_r       <= S_PUSH;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                S_PUSH: begin
                    if (push_s) begin
                        if (blk_idx_r == LAST_BLK) begin
                            frame_done_r <= 1'b1;
                            state_r      <= S_DONE;
                        end else begin
                            blk_idx_r  <= blk_idx_r + IDX_W'(1);
                            cnt_r      <= '0;
                            me_start_r <= 1'b1;
                            state_r    <= S_START;
                        end
                    end
                end
                S_DONE: begin
                    frame_busy_r <= 1'b0;
                    state_r      <= S_IDLE;
                end
                default: begin
                    me_start_r   <= 1'b0;
                    frame_busy_r <= 1'b0;
                    state_r      <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky check: the ME must not report completion while start is still asserted
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            proto_err_r <= 1'b0;
        end else if (me_start_r && me_completed) begin
            proto_err_r <= 1'b1;
        end
    end

    // Result FIFO storage, pointers and occupancy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= entry_s;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + FCNT_W'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - FCNT_W'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

`ifdef ME_SEQ_SAD_ACCUM_EN
    logic [15:0] frame_sad_r;
    logic [16:0] sad_sum_s;

    // Saturating sum of every pushed best_dist, including timeout entries
    always_comb begin
        sad_sum_s = {1'b0, frame_sad_r} + {9'b0_0000_0000, ent_dist_r};
    end

    // Frame SAD accumulator, cleared on frame acceptance
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_sad_r <= 16'h0000;
        end else if ((state_r == S_IDLE) && frame_go) begin
            frame_sad_r <= 16'h0000;
        end else if (push_s) begin
            frame_sad_r <= sad_sum_s[16] ? 16'hFFFF : sad_sum_s[15:0];
        end
    end

    assign frame_sad = frame_sad_r;
`endif

    assign me_start    = me_start_r;
    assign frame_busy  = frame_busy_r;
    assign frame_done  = frame_done_r;
    assign proto_err   = proto_err_r;
    assign timeout_err = timeout_err_r;
    assign res_valid   = (fifo_cnt_r != {FCNT_W{1'b0}});
    assign res_data    = fifo_mem_r[rd_ptr_r];
endmodule
